// File: rtl/serial_rx_frame.sv
// rtl/serial_rx_frame.sv - serial-to-parallel frame receiver with optional parity and ready/ack holding register
module serial_rx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int MSB_FIRST  = 0,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 valid,
    input  logic                 Data_in,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] RxReg_out,
    output logic                 rx_ready,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int CW = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_PARITY,
        S_LOAD
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_q, rx_d;
    logic                 par_bit_q, par_bit_d;
    logic                 rdy_q, rdy_d;
    logic                 perr_q, perr_d;
    logic                 ovr_q, ovr_d;
    logic                 load;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end
            end
            S_SHIFT: begin
                if (MSB_FIRST != 0) begin
                    shift_d = {shift_q[DATA_BITS-2:0], Data_in};
                end else begin
                    shift_d = {Data_in, shift_q[DATA_BITS-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DATA_BITS - 1)) begin
                    state_d = (PARITY_EN != 0) ? S_PARITY : S_LOAD;
                end
            end
            S_PARITY: begin
                par_bit_d = Data_in;
                state_d   = S_LOAD;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign load = (state_q == S_LOAD);

    // A load always wins over a same-edge acknowledge; the ack then consumes the old word.
    always_comb begin
        rx_d   = rx_q;
        rdy_d  = rdy_q;
        perr_d = perr_q;
        ovr_d  = ovr_q;
        if (load) begin
            rx_d   = shift_q;
            perr_d = (PARITY_EN != 0) ? (((^shift_q) ^ par_bit_q) != (PARITY_ODD != 0)) : 1'b0;
            rdy_d  = 1'b1;
            ovr_d  = ovr_q | (rdy_q & ~rd_ack);
        end else if (rd_ack) begin
            rdy_d = 1'b0;
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            rx_q      <= '0;
            rdy_q     <= 1'b0;
            perr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            par_bit_q <= par_bit_d;
            rx_q      <= rx_d;
            rdy_q     <= rdy_d;
            perr_q    <= perr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign RxReg_out  = rx_q;
    assign rx_ready   = rdy_q;
    assign parity_err = perr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_serial_rx_frame.sv
// tb/tb_serial_rx_frame.sv - self-checking bench for serial_rx_frame (LSB-first, MSB-first and even-parity builds)
module tb_serial_rx_frame;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic       valid = 1'b0, data = 1'b0, ack = 1'b0;
    logic [7:0] rx_l, rx_m;
    logic       rdy_l, perr_l, ovr_l, rdy_m, perr_m, ovr_m;

    logic       p_valid = 1'b0, p_data = 1'b0, p_ack = 1'b0;
    logic [7:0] rx_p;
    logic       rdy_p, perr_p, ovr_p;

    serial_rx_frame #(.DATA_BITS(8), .MSB_FIRST(0), .PARITY_EN(0), .PARITY_ODD(0)) dut_lsb (
        .clock(clock), .reset(reset), .valid(valid), .Data_in(data), .rd_ack(ack),
        .RxReg_out(rx_l), .rx_ready(rdy_l), .parity_err(perr_l), .overrun(ovr_l)
    );

    serial_rx_frame #(.DATA_BITS(8), .MSB_FIRST(1), .PARITY_EN(0), .PARITY_ODD(0)) dut_msb (
        .clock(clock), .reset(reset), .valid(valid), .Data_in(data), .rd_ack(ack),
        .RxReg_out(rx_m), .rx_ready(rdy_m), .parity_err(perr_m), .overrun(ovr_m)
    );

    serial_rx_frame #(.DATA_BITS(8), .MSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(0)) dut_par (
        .clock(clock), .reset(reset), .valid(p_valid), .Data_in(p_data), .rd_ack(p_ack),
        .RxReg_out(rx_p), .rx_ready(rdy_p), .parity_err(perr_p), .overrun(ovr_p)
    );

    typedef struct {
        logic [7:0] w;
        logic       p;
    } vec_t;

    typedef struct {
        logic [7:0] lsb;
        logic [7:0] msb;
        logic       perr;
    } exp_t;

    vec_t tbl[6];
    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    logic m_ready = 1'b0, m_ovr = 1'b0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    // Bit i of w is sent i-th on the line.
    task automatic send(input logic [7:0] w, input bit hold_v, input bit ack_load);
        exp_t e;
        e.lsb = w; e.msb = rev8(w); e.perr = 1'b0;
        sb.push_back(e);
        valid = 1'b1;
        tick();
        valid = hold_v;
        for (int i = 0; i < 8; i++) begin
            data = w[i];
            tick();
        end
        check("pre_load_ready", rdy_l, m_ready);
        ack = ack_load;
        tick();
        ack = 1'b0; valid = 1'b0;
        m_ovr   = m_ovr | (m_ready & ~ack_load);
        m_ready = 1'b1;
        e = sb.pop_front();
        check("rx_lsb", rx_l, e.lsb);
        check("rx_msb", rx_m, e.msb);
        check("ready", rdy_l, m_ready);
        check("overrun", ovr_l, m_ovr);
        check("perr_off", perr_l, 1'b0);
    endtask

    task automatic ack_lm();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        m_ready = 1'b0; m_ovr = 1'b0;
        check("ack_ready", rdy_m, m_ready);
        check("ack_overrun", ovr_l, m_ovr);
    endtask

    task automatic send_par(input logic [7:0] w, input logic p);
        exp_t e;
        e.lsb = w; e.msb = rev8(w);
        e.perr = (^w) ^ p;   // even parity: error when total ones is odd
        sb.push_back(e);
        p_valid = 1'b1;
        tick();
        p_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            p_data = w[i];
            tick();
        end
        p_data = p;
        tick();
        check("par_pre_load_ready", rdy_p, 1'b0);
        tick();
        e = sb.pop_front();
        check("par_rx", rx_p, e.lsb);
        check("par_err", perr_p, e.perr);
        check("par_ready", rdy_p, 1'b1);
        p_ack = 1'b1;
        tick();
        p_ack = 1'b0;
        check("par_ack_ready", rdy_p, 1'b0);
    endtask

    initial begin
        tbl[0] = '{8'h4D, 1'b0};
        tbl[1] = '{8'h4D, 1'b1};
        tbl[2] = '{8'h00, 1'b0};
        tbl[3] = '{8'hFF, 1'b1};
        tbl[4] = '{8'h80, 1'b1};
        tbl[5] = '{8'h01, 1'b0};

        tick();
        tick();
        check("rst_rx", rx_l, 8'h00);
        check("rst_ready", rdy_l, 1'b0);
        check("rst_perr", perr_l, 1'b0);
        check("rst_overrun", ovr_l, 1'b0);
        check("rst_par_rx", rx_p, 8'h00);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            send(tbl[i].w, 1'b0, 1'b0);
            ack_lm();
        end

        ack_lm();
        check("idle_ack_ready", rdy_l, 1'b0);

        send(8'h12, 1'b0, 1'b0);
        send(8'h34, 1'b0, 1'b0);
        ack_lm();

        send(8'h56, 1'b0, 1'b0);
        send(8'h78, 1'b0, 1'b1);
        ack_lm();

        for (int i = 0; i < 6; i++) begin
            send_par(tbl[i].w, tbl[i].p);
        end

        valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data = i[0];
            tick();
        end
        #2 reset = 1'b1;
        #1;
        check("midrst_rx", rx_l, 8'h00);
        check("midrst_ready", rdy_l, 1'b0);
        check("midrst_par_rx", rx_p, 8'h00);
        m_ready = 1'b0; m_ovr = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        send(8'hA5, 1'b1, 1'b0);
        ack_lm();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
